alu32_share_arb: RTL and testbench
==================================

// Module: alu32_share_arb
// PURPOSE
//  Shares one alu32 instance between two requesters (e.g. fetch/address unit and
//  execute unit) with valid/ready handshakes. Round-robin arbitration, one operation
//  in flight, registered result + flags returned on a single response channel tagged
//  with requester id. Sits between requester logic and the shared alu32 datapath.
// PARAMETERS
//  PRIO_FIXED  0   1 = requester 0 always wins a tie; 0 = round-robin
//  CNT_W       16  width of the completed-operation counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 operation accepted this cycle (valid&ready)
//  req0_a       in   32     operand A
//  req0_b       in   32     operand B
//  req0_f       in   2      op: 00 ADD, 01 SUB, 10 AND, 11 OR
//  req1_valid/req1_ready/req1_a/req1_b/req1_f   same as requester 0
//  rsp_valid    out  1      response held valid
//  rsp_ready    in   1      consumer accepts response
//  rsp_id       out  1      requester that issued the operation
//  rsp_y        out  32     ALU result
//  rsp_flags    out  4      {Zero, Overflow, Carry, Neg}
//  busy         out  1      state != IDLE
//  op_count     out  CNT_W  completed responses, saturating
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flags=0, op_count=0,
//   last_grant=1 (requester 0 wins first tie). Reset overrides any in-flight op;
//   the op is discarded, no response produced.
//  FSM: IDLE -> EXEC on accept; EXEC -> RESP always (1 cycle); RESP -> IDLE on
//   rsp_valid&rsp_ready, else stay in RESP holding all rsp_* stable.
//  Grant (combinational, IDLE only): one valid -> that one; both valid -> PRIO_FIXED ?
//   0 : ~last_grant. reqN_ready = (state==IDLE) & grant==N; never both high;
//   both 0 outside IDLE. Ready does not depend on rsp_ready.
//  Accept: on valid&ready, latch a, b, f and id into op registers; last_grant<=id.
//   Requesters hold a/b/f stable while valid & ~ready; dropping valid before
//   acceptance is permitted and cancels the request.
//  EXEC: alu32 driven from op registers only; at end of EXEC capture
//   rsp_y<=Y, Zero<=Y==0, Overflow<=ALU Overflow (0 for AND/OR), Carry<=carry-out
//   of A+B (ADD) or A+~B+1 (SUB; 1 = no borrow), 0 for AND/OR, Neg<=Y[31];
//   rsp_id<=latched id; rsp_valid<=1.
//  Latency: accept at edge N -> rsp_valid high after edge N+2. Minimum 3 cycles per
//   op (accept, exec, resp handshake); next accept possible in the cycle after the
//   response handshake.
//  op_count increments on each response handshake; saturates at 2^CNT_W-1.
//  A requester's valid during EXEC/RESP is ignored (ready=0) and waits in IDLE.
//  Wrap: ADD/SUB results are modulo 2^32; carry-out goes to Carry only.
// TESTING
//  Reset: assert reset 2 cycles mid-EXEC -> rsp_valid=0, op_count=0, busy=0,
//   no response follows.
//  Single op: req0 ADD a=7 b=5, rsp_ready=1 -> rsp_valid 2 cycles after accept,
//   rsp_y=12, id=0, flags=0000.
//  Tie: both valid at reset exit (req0 SUB 5-5, req1 OR 0xF0|0x0F) -> req0 served
//   first (y=0, Zero=1, Carry=1), then req1 (y=0xFF, id=1); third tie grants req0.
//  Overflow: req1 SUB 0x80000000-1 -> y=0x7FFFFFFF, Overflow=1, Carry=1, Neg=0;
//   ADD 0xFFFFFFFF+1 -> y=0, Zero=1, Carry=1, Overflow=0.
//  Backpressure: rsp_ready=0 for 4 cycles -> rsp_* stable, both req_ready=0,
//   op_count unchanged until handshake, then +1.
//  PRIO_FIXED=1: both valid continuously -> req0 granted every time, req1 never.

Source files
------------

// File: rtl/alu32_share_arb.sv
// rtl/alu32_share_arb.sv - two-requester round-robin front end sharing one alu32
`timescale 1ns/1ps

// alu32 - 32-bit ADD/SUB/AND/OR with carry (1 = no borrow on SUB) and overflow
module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  f,
  output logic [31:0] y,
  output logic        overflow,
  output logic        carry
);

  logic [32:0] sum;
  logic [31:0] b_eff;

  // SUB is A + ~B + 1 so carry-out doubles as the no-borrow indication
  assign b_eff = f[0] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'd0, f[0]};

  always_comb begin
    y        = sum[31:0];
    carry    = sum[32];
    overflow = ~(a[31] ^ b_eff[31]) & (sum[31] ^ a[31]);
    case (f)
      2'b10: begin
        y        = a & b;
        carry    = 1'b0;
        overflow = 1'b0;
      end
      2'b11: begin
        y        = a | b;
        carry    = 1'b0;
        overflow = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

module alu32_share_arb #(
  parameter bit PRIO_FIXED = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [1:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req1_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nx;
  logic        last_grant;
  logic        grant;
  logic        grant_vld;
  logic        accept;
  logic        rsp_hs;
  logic [31:0] op_a, op_b;
  logic [1:0]  op_f;
  logic        op_id;
  logic [31:0] alu_y;
  logic        alu_ov, alu_c;

  alu32 u_alu (
    .a        (op_a),
    .b        (op_b),
    .f        (op_f),
    .y        (alu_y),
    .overflow (alu_ov),
    .carry    (alu_c)
  );

  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      grant = PRIO_FIXED ? 1'b0 : ~last_grant;
    else
      grant = ~req0_valid;
  end

  assign accept = req0_ready | req1_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) & grant_vld & ~grant;
    req1_ready = (state == IDLE) & grant_vld & grant;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_f       <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_flags  <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        op_a       <= grant ? req1_a : req0_a;
        op_b       <= grant ? req1_b : req0_b;
        op_f       <= grant ? req1_f : req0_f;
        op_id      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_y     <= alu_y;
        rsp_flags <= {alu_y == 32'd0, alu_ov, alu_c, alu_y[31]};
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_hs && op_count != CNT_MAX)
        op_count <= op_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu32_share_arb.sv
// tb/tb_alu32_share_arb.sv - scoreboard bench for alu32_share_arb
`timescale 1ns/1ps

module tb_alu32_share_arb;

  localparam int CW = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    bit          has_exp;
    logic [31:0] ey;
    logic [3:0]  ef;
  } op_t;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic [3:0]  fl;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0v, r0r, r1v, r1r;
  logic [31:0]   r0a, r0b, r1a, r1b;
  logic [1:0]    r0f, r1f;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0]   rsp_y;
  logic [3:0]    rsp_flags;
  logic [CW-1:0] op_count;

  logic          f_reset, f0v, f0r, f1v, f1r;
  logic          f_rsp_valid, f_rsp_ready, f_rsp_id, f_busy;
  logic [31:0]   f_rsp_y;
  logic [3:0]    f_rsp_flags;
  logic [15:0]   f_op_count;

  int   n_checks = 0;
  int   n_err    = 0;
  op_t  q0[$], q1[$];
  exp_t sb[$];
  op_t  cur0, cur1;
  bit   acc0 = 0, acc1 = 0;
  bit   cancel_en = 0, bp_rand = 0;
  int   cyc = 0, acc_cyc = 0, acc_total = 0;
  int   m_cnt = 0, m_hs = 0;
  logic m_last = 1'b1;

  always #5 clk = ~clk;

  alu32_share_arb #(.PRIO_FIXED(1'b0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_f(r0f),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_f(r1f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .busy(busy), .op_count(op_count)
  );

  alu32_share_arb #(.PRIO_FIXED(1'b1), .CNT_W(16)) dut_fix (
    .clk(clk), .reset(f_reset),
    .req0_valid(f0v), .req0_ready(f0r), .req0_a(32'd3), .req0_b(32'd4), .req0_f(2'b00),
    .req1_valid(f1v), .req1_ready(f1r), .req1_a(32'd1), .req1_b(32'd2), .req1_f(2'b11),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_y(f_rsp_y),
    .rsp_flags(f_rsp_flags), .busy(f_busy), .op_count(f_op_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning
  function automatic exp_t model(input logic id, input op_t o);
    exp_t   e;
    longint sr;
    longint unsigned ur;
    logic   v, c;
    e.id = id;
    v = 1'b0;
    c = 1'b0;
    case (o.f)
      2'b00: begin
        ur  = longint'(o.a) + longint'(o.b);
        c   = ur > 64'h0000_0000_FFFF_FFFF;
        e.y = o.a + o.b;
        sr  = longint'($signed(o.a)) + longint'($signed(o.b));
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b01: begin
        c   = o.a >= o.b;
        e.y = o.a - o.b;
        sr  = longint'($signed(o.a)) - longint'($signed(o.b));
        v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b10:   e.y = o.a & o.b;
      default: e.y = o.a | o.b;
    endcase
    e.fl = {e.y == 32'd0, v, c, e.y[31]};
    return e;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    op_t o;
    o.a = a; o.b = b; o.f = f; o.has_exp = 0; o.ey = '0; o.ef = '0;
    return o;
  endfunction

  function automatic op_t mkx(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                              input logic [31:0] ey, input logic [3:0] ef);
    op_t o;
    o = mk(a, b, f);
    o.has_exp = 1; o.ey = ey; o.ef = ef;
    return o;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  function automatic exp_t expect_of(input logic id, input op_t o);
    exp_t e;
    if (o.has_exp) begin
      e.id = id; e.y = o.ey; e.fl = o.ef;
    end else begin
      e = model(id, o);
    end
    return e;
  endfunction

  // Requester drivers: hold an op until accepted, optionally cancel it
  initial begin
    r0v = 0; r1v = 0; r0a = 0; r0b = 0; r0f = 0; r1a = 0; r1b = 0; r1f = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_rand) rsp_ready = ($urandom_range(0, 2) != 0);
      if (acc0) begin
        r0v = 0; acc0 = 0;
      end else if (r0v && cancel_en && $urandom_range(0, 7) == 0) begin
        r0v = 0;
      end
      if (!r0v && q0.size() > 0 && (!cancel_en || $urandom_range(0, 1) == 1)) begin
        cur0 = q0.pop_front();
        r0a = cur0.a; r0b = cur0.b; r0f = cur0.f; r0v = 1;
      end
      if (acc1) begin
        r1v = 0; acc1 = 0;
      end else if (r1v && cancel_en && $urandom_range(0, 7) == 0) begin
        r1v = 0;
      end
      if (!r1v && q1.size() > 0 && (!cancel_en || $urandom_range(0, 1) == 1)) begin
        cur1 = q1.pop_front();
        r1a = cur1.a; r1b = cur1.b; r1f = cur1.f; r1v = 1;
      end
    end
  end

  // Monitor: arbitration rules, accepts into scoreboard, response compare
  logic        prev_hold = 0, prev_valid = 0, prev_id = 0;
  logic [31:0] prev_y = 0;
  logic [3:0]  prev_fl = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb.delete();
        m_cnt = 0; m_last = 1'b1; prev_hold = 0; prev_valid = 0;
      end else begin
        chk("op_count", 64'(op_count), 64'(m_cnt));
        chk("ready_onehot", 64'(r0r & r1r), 0);
        if (busy) begin
          chk("ready_busy", 64'(r0r | r1r), 0);
        end else if (r0v && r1v) begin
          chk("tie_grant", {r1r, r0r}, m_last ? 64'b01 : 64'b10);
        end else if (r0v) begin
          chk("grant0", {r1r, r0r}, 64'b01);
        end else if (r1v) begin
          chk("grant1", {r1r, r0r}, 64'b10);
        end
        if (r0v && r0r) begin
          sb.push_back(expect_of(1'b0, cur0));
          m_last = 1'b0; acc0 = 1; acc_cyc = cyc; acc_total++;
        end
        if (r1v && r1r) begin
          sb.push_back(expect_of(1'b1, cur1));
          m_last = 1'b1; acc1 = 1; acc_cyc = cyc; acc_total++;
        end
        if (prev_hold)
          chk("hold", {rsp_valid, rsp_id, rsp_flags, rsp_y}, {1'b1, prev_id, prev_fl, prev_y});
        if (rsp_valid && !prev_valid)
          chk("latency", 64'(cyc - acc_cyc), 2);
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_y", 64'(rsp_y), 64'(e.y));
            chk("rsp_flags", 64'(rsp_flags), 64'(e.fl));
          end
          m_hs++;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        prev_hold  = rsp_valid & ~rsp_ready;
        prev_valid = rsp_valid;
        prev_id    = rsp_id;
        prev_y     = rsp_y;
        prev_fl    = rsp_flags;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(q0.size() == 0 && q1.size() == 0 && !r0v && !r1v &&
                           sb.size() == 0 && !rsp_valid)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int n, base, nresp;
    reset = 1; rsp_ready = 1;
    f_reset = 1; f0v = 0; f1v = 0; f_rsp_ready = 1;

    // Tie at reset exit: req0, req1, req0 again, req1
    q0.push_back(mkx(32'd5, 32'd5, 2'b01, 32'h0, 4'b1010));
    q0.push_back(mkx(32'd7, 32'd5, 2'b00, 32'd12, 4'b0000));
    q1.push_back(mkx(32'hF0, 32'h0F, 2'b11, 32'hFF, 4'b0000));
    q1.push_back(mkx(32'h8000_0000, 32'd1, 2'b01, 32'h7FFF_FFFF, 4'b0110));
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_flags, rsp_y}, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cnt", 64'(op_count), 0);
    wait_drain(200);

    // Lone requests
    q0.push_back(mkx(32'd7, 32'd5, 2'b00, 32'd12, 4'b0000));
    wait_drain(50);
    q0.push_back(mkx(32'hFFFF_FFFF, 32'd1, 2'b00, 32'h0, 4'b1010));
    wait_drain(50);

    // Backpressure: stall the first response for 4 cycles
    rsp_ready = 0;
    q0.push_back(mk(32'd1, 32'd2, 2'b00));
    q1.push_back(mk(32'hF0F0, 32'h0FF0, 2'b10));
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk("bp_rsp_seen", 64'(rsp_valid), 1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready", {r1r, r0r}, 0);
      chk("bp_cnt", 64'(op_count), 6);
    end
    @(posedge clk); #1 rsp_ready = 1;
    wait_drain(100);
    chk("bp_cnt_after", 64'(op_count), 8);

    // Reset during EXEC discards the op
    base = acc_total;
    q0.push_back(mk(32'd9, 32'd9, 2'b00));
    n = 0;
    while (acc_total == base && n < 20) begin @(negedge clk); n++; end
    chk("mid_accept", 64'(acc_total - base), 1);
    @(posedge clk); #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(rsp_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_cnt", 64'(op_count), 0);
    repeat (6) @(negedge clk);
    chk("mid_rst_norsp", 64'(rsp_valid), 0);

    // Random traffic with cancels and random response backpressure
    cancel_en = 1; bp_rand = 1;
    for (int i = 0; i < 25; i++) begin
      q0.push_back(mk(rnd32(), rnd32(), 2'($urandom_range(0, 3))));
      q1.push_back(mk(rnd32(), rnd32(), 2'($urandom_range(0, 3))));
    end
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 3000) begin @(negedge clk); n++; end
    cancel_en = 0;
    wait_drain(200);
    bp_rand = 0;
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    if (m_hs >= 15) chk("saturate", 64'(op_count), 15);

    // Fixed priority instance: both requesters valid throughout
    @(posedge clk); #1 f_reset = 0; f0v = 1; f1v = 1;
    nresp = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk("fix_r1_ready", 64'(f1r), 0);
      if (!f_busy) chk("fix_r0_ready", 64'(f0r), 1);
      if (f_rsp_valid) begin
        chk("fix_rsp", {f_rsp_id, f_rsp_flags, f_rsp_y}, {1'b0, 4'b0000, 32'd7});
        nresp++;
      end
    end
    @(negedge clk);
    chk("fix_count", 64'(f_op_count), 64'(nresp));
    chk("fix_served", 64'(nresp >= 12), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
